// File: rtl/div_iter.sv
// Iterative restoring divider: BITS_PER_CYCLE quotient bits per CALC cycle on operand
// magnitudes, followed by a single sign fix-up cycle. Supports squash via flush.
module div_iter #(
    parameter int XLEN           = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [CW-1:0]   r_cnt;
    logic [XLEN:0]   r_rem;
    logic [XLEN-1:0] r_dvd;
    logic [XLEN-1:0] r_dsr;
    logic [XLEN-1:0] r_origDvd;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_remOut;
    logic            r_negQ;
    logic            r_negR;
    logic            r_div0;

    logic            w_accept;
    logic            w_lastCalc;
    logic [XLEN-1:0] w_absDvd;
    logic [XLEN-1:0] w_absDsr;
    logic [XLEN:0]   w_remNext;
    logic [XLEN-1:0] w_dvdNext;
    logic [XLEN:0]   w_diff;

    assign ready      = (r_state == IDLE) || (r_state == DONE);
    assign done       = (r_state == DONE);
    assign quotient   = r_quot;
    assign remainder  = r_remOut;
    assign w_accept   = ready && start && !flush;
    assign w_lastCalc = (r_state == CALC) && (r_cnt == CW'(N - 1));

    assign w_absDvd = (is_signed && dividend[XLEN-1]) ? (~dividend + 1'b1) : dividend;
    assign w_absDsr = (is_signed && divisor[XLEN-1])  ? (~divisor + 1'b1)  : divisor;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (flush) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_nextState = CALC;
                CALC:    if (w_lastCalc) w_nextState = FIX;
                FIX:     w_nextState = DONE;
                DONE:    w_nextState = start ? CALC : IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // The dividend register shifts its MSB into the partial remainder while quotient
    // bits enter at its LSB, so after N cycles it holds the unsigned quotient.
    always_comb begin
        w_remNext = r_rem;
        w_dvdNext = r_dvd;
        w_diff    = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            w_remNext = {w_remNext[XLEN-1:0], w_dvdNext[XLEN-1]};
            w_dvdNext = {w_dvdNext[XLEN-2:0], 1'b0};
            w_diff    = w_remNext - {1'b0, r_dsr};
            if (!w_diff[XLEN]) begin
                w_remNext    = w_diff;
                w_dvdNext[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_dsr     <= '0;
            r_origDvd <= '0;
            r_quot    <= '0;
            r_remOut  <= '0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_div0    <= 1'b0;
        end else if (w_accept) begin
            r_negQ    <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            r_negR    <= is_signed && dividend[XLEN-1];
            r_div0    <= (divisor == '0);
            r_origDvd <= dividend;
            r_dvd     <= w_absDvd;
            r_dsr     <= w_absDsr;
            r_rem     <= '0;
            r_cnt     <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                CALC: begin
                    r_rem <= w_remNext;
                    r_dvd <= w_dvdNext;
                    r_cnt <= w_lastCalc ? '0 : (r_cnt + CW'(1));
                end
                FIX: begin
                    // Divide by zero bypasses the sign fix-up entirely.
                    if (r_div0) begin
                        r_quot   <= '1;
                        r_remOut <= r_origDvd;
                    end else begin
                        r_quot   <= r_negQ ? (~r_dvd + 1'b1) : r_dvd;
                        r_remOut <= r_negR ? (~r_rem[XLEN-1:0] + 1'b1) : r_rem[XLEN-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: directed vectors push expected results and done cycle;
// monitors pop and compare whenever done is seen.
module tb_div_iter;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic        isSigned;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        ready;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;

    logic        start4;
    logic        flush4;
    logic        isSigned4;
    logic [63:0] dividend4;
    logic [63:0] divisor4;
    logic        ready4;
    logic        done4;
    logic [63:0] quotient4;
    logic [63:0] remainder4;

    exp_t sbQ[$];
    exp_t sbQ4[$];
    exp_t mE;
    exp_t mE4;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   doneCount   = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    div_iter #(.XLEN(64), .BITS_PER_CYCLE(1)) dut (
        .clock(clock), .reset(reset), .start(start), .flush(flush),
        .is_signed(isSigned), .dividend(dividend), .divisor(divisor),
        .ready(ready), .done(done), .quotient(quotient), .remainder(remainder)
    );

    div_iter #(.XLEN(64), .BITS_PER_CYCLE(4)) dut4 (
        .clock(clock), .reset(reset), .start(start4), .flush(flush4),
        .is_signed(isSigned4), .dividend(dividend4), .divisor(divisor4),
        .ready(ready4), .done(done4), .quotient(quotient4), .remainder(remainder4)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (done === 1'b1) begin
            doneCount++;
            if (sbQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected done: cycle %0d, expected no done", cyc);
            end else begin
                mE = sbQ.pop_front();
                checkOutput("quotient", quotient, mE.q);
                checkOutput("remainder", remainder, mE.r);
                checkOutput("done cycle", 64'(cyc), 64'(mE.cyc));
            end
        end
    end

    always @(negedge clock) begin
        if (done4 === 1'b1) begin
            if (sbQ4.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected done4: cycle %0d, expected no done", cyc);
            end else begin
                mE4 = sbQ4.pop_front();
                checkOutput("quotient bpc4", quotient4, mE4.q);
                checkOutput("remainder bpc4", remainder4, mE4.r);
                checkOutput("done cycle bpc4", 64'(cyc), 64'(mE4.cyc));
            end
        end
    end

    // Drives one start cycle from the current time; caller positions away from the edge.
    task automatic applyStimulus(input logic sgn, input logic [63:0] a, input logic [63:0] b,
                                 input logic push, input logic [63:0] eq, input logic [63:0] er);
        start    = 1'b1;
        isSigned = sgn;
        dividend = a;
        divisor  = b;
        if (push) sbQ.push_back('{eq, er, cyc + 66});
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sbQ.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (sbQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain timeout: %0d pending, expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        @(negedge clock);
        while (done !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (done !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL done timeout: done=%b, expected 1", done);
        end
    endtask

    task automatic runOp(input logic sgn, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] eq, input logic [63:0] er);
        applyStimulus(sgn, a, b, 1'b1, eq, er);
        waitDrain(80);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int badReady;
        int dc;

        reset     = 1'b1;
        start     = 1'b0;
        flush     = 1'b0;
        isSigned  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        start4    = 1'b0;
        flush4    = 1'b0;
        isSigned4 = 1'b0;
        dividend4 = '0;
        divisor4  = '0;
        #1 reset = 1'b0;
        #3;
        checkOutput("reset ready", 64'(ready), 64'd1);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset quotient", quotient, 64'd0);
        checkOutput("reset remainder", remainder, 64'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;

        // Unsigned 100/7 with ready low for the whole operation.
        applyStimulus(1'b0, 64'd100, 64'd7, 1'b1, 64'd14, 64'd2);
        badReady = 0;
        for (int i = 0; i < 65; i++) begin
            @(negedge clock);
            if (ready !== 1'b0) badReady++;
        end
        checkOutput("ready high during op", 64'(badReady), 64'd0);
        waitDrain(20);
        @(posedge clock);
        #1;

        runOp(1'b1, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, -64'sd2);
        runOp(1'b1, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2);
        runOp(1'b1, -64'sd100, -64'sd7, 64'd14, -64'sd2);
        runOp(1'b1, -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB);
        runOp(1'b0, 64'd37, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd37);
        runOp(1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 64'd0);
        runOp(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        runOp(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 64'd15);

        // Mid-op start is ignored; start in the DONE cycle runs back-to-back.
        dc = doneCount;
        applyStimulus(1'b0, 64'd50, 64'd5, 1'b1, 64'd10, 64'd0);
        repeat (9) @(posedge clock);
        #1 applyStimulus(1'b0, 64'd9, 64'd2, 1'b0, 64'd0, 64'd0);
        waitDone(80);
        applyStimulus(1'b0, 64'd9, 64'd2, 1'b1, 64'd4, 64'd1);
        waitDrain(80);
        checkOutput("dones for ignored start", 64'(doneCount - dc), 64'd2);
        @(posedge clock);
        #1;

        // Flush at cycle 30 of the op.
        dc = doneCount;
        applyStimulus(1'b0, 64'd200, 64'd3, 1'b0, 64'd0, 64'd0);
        repeat (29) @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        checkOutput("flush ready", 64'(ready), 64'd1);
        checkOutput("flush quotient held", quotient, 64'd4);
        checkOutput("flush remainder held", remainder, 64'd1);
        repeat (70) @(negedge clock);
        checkOutput("flush no done", 64'(doneCount - dc), 64'd0);
        @(posedge clock);
        #1;

        // Reset pulled at cycle 40 of an op.
        dc = doneCount;
        applyStimulus(1'b0, 64'd1000, 64'd9, 1'b0, 64'd0, 64'd0);
        repeat (39) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        checkOutput("midop reset ready", 64'(ready), 64'd1);
        checkOutput("midop reset done", 64'(done), 64'd0);
        checkOutput("midop reset quotient", quotient, 64'd0);
        checkOutput("midop reset remainder", remainder, 64'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (70) @(negedge clock);
        checkOutput("midop reset no done", 64'(doneCount - dc), 64'd0);
        @(posedge clock);
        #1;

        // Four bits per cycle: done 18 cycles after the start cycle.
        start4    = 1'b1;
        isSigned4 = 1'b0;
        dividend4 = 64'd100;
        divisor4  = 64'd7;
        sbQ4.push_back('{64'd14, 64'd2, cyc + 18});
        @(posedge clock);
        #1 start4 = 1'b0;
        for (int i = 0; i < 40 && sbQ4.size() != 0; i++) @(negedge clock);
        if (sbQ4.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL bpc4 timeout: %0d pending, expected 0", sbQ4.size());
        end
        repeat (3) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
